// File: rtl/inst_rom_pipe_pkg.sv
// Shared constants and helpers for the pipelined instruction ROM.
package inst_rom_pipe_pkg;

    localparam int unsigned MaxReadLatency = 3;
    localparam logic [31:0] ImageBase      = 32'h7856_3412;

    localparam logic FaultNone = 1'b0;
    localparam logic FaultAddr = 1'b1;

    // Out-of-range latencies fall back to the nearest legal value.
    function automatic int unsigned clamp_latency(int unsigned lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > MaxReadLatency) begin
            return MaxReadLatency;
        end
        return lat;
    endfunction

    function automatic int unsigned rsp_depth(int unsigned lat);
        return clamp_latency(lat) + 1;
    endfunction

endpackage

// File: rtl/inst_rom_pipe_rsp_fifo.sv
// Synchronous response FIFO holding {fault, addr, data}; clear empties it in one edge.
module inst_rom_pipe_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: the top masks the head while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/inst_rom_pipe.sv
// Pipelined instruction ROM with valid/ready request and response channels, fault
// detection, optional byte swap, flush, and a response FIFO sized for full throughput.
module inst_rom_pipe
    import inst_rom_pipe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          BYTE_SWAP    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [31:0]           rsp_addr_o,
    output logic                  rsp_fault_o
);

    localparam int unsigned Lat      = clamp_latency(READ_LATENCY);
    localparam int unsigned RspDepth = rsp_depth(READ_LATENCY);
    localparam int unsigned RomDepth = 2 ** ADDR_WIDTH;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned EntryW   = 1 + 32 + DATA_WIDTH;
    localparam int unsigned OutW     = $clog2(RspDepth + 1);

    logic [DATA_WIDTH-1:0] rom [RomDepth];

    for (genvar k = 0; k < RomDepth; k++) begin : g_rom
        assign rom[k] = DATA_WIDTH'(ImageBase + 32'(k));
    end

    logic                  req_fault;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_swapped;
    logic                  accept;
    logic                  pop;
    logic [OutW-1:0]       outstanding_q;
    logic [OutW-1:0]       outstanding_d;

    logic [Lat-1:0]        stg_valid_q;
    logic [Lat-1:0]        stg_fault_q;
    logic [31:0]           stg_addr_q [Lat];
    logic [DATA_WIDTH-1:0] stg_data_q [Lat];

    logic [EntryW-1:0]     fifo_rdata;
    logic                  fifo_empty;

    assign req_fault = ((req_addr_i[1:0] != 2'b00) || (req_addr_i[31:ADDR_WIDTH+2] != '0))
                       ? FaultAddr : FaultNone;
    assign rd_idx    = req_fault ? '0 : req_addr_i[ADDR_WIDTH+1:2];

    always_comb begin
        rd_word    = rom[rd_idx];
        rd_swapped = rd_word;
        if (BYTE_SWAP) begin
            for (int i = 0; i < NumBytes; i++) begin
                rd_swapped[8*i +: 8] = rd_word[8*(NumBytes-1-i) +: 8];
            end
        end
    end

    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i && !flush_i;
    // A same-cycle pop frees a slot, so a full pipeline can still take a new request.
    assign req_ready_o = !rst_i && !flush_i && ((outstanding_q < OutW'(RspDepth)) || pop);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        outstanding_d = outstanding_q;
        if (flush_i) begin
            outstanding_d = '0;
        end else if (accept && !pop) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Stage 0 is the registered ROM read; later stages only add delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_valid_q <= '0;
            stg_fault_q <= '0;
            for (int i = 0; i < Lat; i++) begin
                stg_addr_q[i] <= '0;
                stg_data_q[i] <= '0;
            end
        end else if (flush_i) begin
            stg_valid_q <= '0;
        end else begin
            stg_valid_q[0] <= accept;
            if (accept) begin
                stg_fault_q[0] <= req_fault;
                stg_addr_q[0]  <= req_addr_i;
                stg_data_q[0]  <= req_fault ? '0 : rd_swapped;
            end
            for (int i = 1; i < Lat; i++) begin
                stg_valid_q[i] <= stg_valid_q[i-1];
                stg_fault_q[i] <= stg_fault_q[i-1];
                stg_addr_q[i]  <= stg_addr_q[i-1];
                stg_data_q[i]  <= stg_data_q[i-1];
            end
        end
    end

    inst_rom_pipe_rsp_fifo #(
        .WIDTH (EntryW),
        .DEPTH (RspDepth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (stg_valid_q[Lat-1]),
        .wdata_i ({stg_fault_q[Lat-1], stg_addr_q[Lat-1], stg_data_q[Lat-1]}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty)
    );

    assign {rsp_fault_o, rsp_addr_o, rsp_data_o} = fifo_empty ? '0 : fifo_rdata;

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Directed bench: instance 0 is READ_LATENCY=1/BYTE_SWAP=1, instance 1 is READ_LATENCY=3/BYTE_SWAP=0.
module tb_inst_rom_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0]       flush;
    logic [1:0]       rsp_ready;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0][31:0] rsp_data;
    logic [1:0][31:0] rsp_addr;
    logic [1:0]       rsp_fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] t1_exp [2][3];

    inst_rom_pipe #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (32),
        .READ_LATENCY (1),
        .BYTE_SWAP    (1'b1)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_addr_i  (req_addr[0]),
        .flush_i     (flush[0]),
        .rsp_valid_o (rsp_valid[0]),
        .rsp_ready_i (rsp_ready[0]),
        .rsp_data_o  (rsp_data[0]),
        .rsp_addr_o  (rsp_addr[0]),
        .rsp_fault_o (rsp_fault[0])
    );

    inst_rom_pipe #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (32),
        .READ_LATENCY (3),
        .BYTE_SWAP    (1'b0)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_addr_i  (req_addr[1]),
        .flush_i     (flush[1]),
        .rsp_valid_o (rsp_valid[1]),
        .rsp_ready_i (rsp_ready[1]),
        .rsp_data_o  (rsp_data[1]),
        .rsp_addr_o  (rsp_addr[1]),
        .rsp_fault_o (rsp_fault[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit swap_of(input int d);
        return (d == 0);
    endfunction

    // Image word k is 0x78563412 + k; optionally byte-reversed on output.
    function automatic logic [31:0] word_exp(input int k, input bit swap);
        logic [31:0] w;
        w = 32'h7856_3412 + 32'(k);
        return swap ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic single(input int d, input logic [31:0] addr, input logic exp_fault,
                          input logic [31:0] exp_data);
        int seen;
        seen = -1;
        rsp_ready[d] = 1'b1;
        req_addr[d]  = addr;
        req_valid[d] = 1'b1;
        #1;
        chk("single_ready", 64'(req_ready[d]), 64'(1));
        tick();
        req_valid[d] = 1'b0;
        for (int t = 1; t <= lat_of(d) + 4; t++) begin
            tick();
            if (rsp_valid[d]) begin
                seen = t;
                break;
            end
        end
        chk("single_latency", 64'(seen), 64'(lat_of(d)));
        chk("single_addr", 64'(rsp_addr[d]), 64'(addr));
        chk("single_fault", 64'(rsp_fault[d]), 64'(exp_fault));
        chk("single_data", 64'(rsp_data[d]), 64'(exp_data));
        tick();
        chk("single_no_dup", 64'(rsp_valid[d]), 64'(0));
    endtask

    task automatic drain(input int d, input int first, input int n);
        int got;
        got = 0;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid[d]) begin
                chk("drain_addr", 64'(rsp_addr[d]), 64'(32'(4 * (first + got))));
                chk("drain_data", 64'(rsp_data[d]), 64'(word_exp(first + got, swap_of(d))));
                got++;
            end
            tick();
        end
        chk("drain_count", 64'(got), 64'(n));
    endtask

    task automatic back_to_back(input int d);
        int k;
        rsp_ready[d] = 1'b1;
        for (int t = 0; t < lat_of(d) + 4; t++) begin
            req_valid[d] = (t < 3);
            req_addr[d]  = 32'(4 * t);
            #1;
            if (t < 3) begin
                chk("b2b_ready", 64'(req_ready[d]), 64'(1));
            end
            tick();
            k = t - lat_of(d);
            if (k >= 0 && k < 3) begin
                chk("b2b_valid", 64'(rsp_valid[d]), 64'(1));
                chk("b2b_data", 64'(rsp_data[d]), 64'(t1_exp[d][k]));
                chk("b2b_addr", 64'(rsp_addr[d]), 64'(32'(4 * k)));
            end else begin
                chk("b2b_idle", 64'(rsp_valid[d]), 64'(0));
            end
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic back_pressure(input int d);
        int acc;
        acc = 0;
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr[d] = 32'h20 + 32'(4 * acc);
            #1;
            if (req_ready[d]) begin
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'(lat_of(d) + 1));
        chk("bp_ready_low", 64'(req_ready[d]), 64'(0));
        req_valid[d] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 64'(rsp_valid[d]), 64'(1));
            chk("bp_hold_addr", 64'(rsp_addr[d]), 64'(32'h20));
            chk("bp_hold_data", 64'(rsp_data[d]), 64'(word_exp(8, swap_of(d))));
            tick();
        end
        drain(d, 8, lat_of(d) + 1);
    endtask

    task automatic accept_pop_full(input int d);
        int l;
        l = lat_of(d);
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b1;
        for (int i = 0; i <= l; i++) begin
            req_addr[d] = 32'(4 * (20 + i));
            #1;
            chk("full_fill_ready", 64'(req_ready[d]), 64'(1));
            tick();
        end
        req_valid[d] = 1'b0;
        repeat (l) tick();
        chk("full_ready_low", 64'(req_ready[d]), 64'(0));
        chk("full_head", 64'(rsp_addr[d]), 64'(32'(4 * 20)));
        req_addr[d]  = 32'(4 * (21 + l));
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        #1;
        chk("accpop_ready", 64'(req_ready[d]), 64'(1));
        tick();
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        #1;
        chk("accpop_still_full", 64'(req_ready[d]), 64'(0));
        drain(d, 21, l + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        t1_exp = '{'{32'h1234_5678, 32'h1334_5678, 32'h1434_5678},
                   '{32'h7856_3412, 32'h7856_3413, 32'h7856_3414}};
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        flush     = '0;
        rsp_ready = '0;

        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 64'(rsp_valid[d]), 64'(0));
            chk("rst_data", 64'(rsp_data[d]), 64'(0));
            chk("rst_addr", 64'(rsp_addr[d]), 64'(0));
            chk("rst_fault", 64'(rsp_fault[d]), 64'(0));
            chk("rst_ready", 64'(req_ready[d]), 64'(0));
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready_a", 64'(req_ready[0]), 64'(1));
        chk("post_rst_ready_b", 64'(req_ready[1]), 64'(1));
        tick();

        back_to_back(0);
        back_to_back(1);
        back_pressure(0);
        back_pressure(1);

        single(0, 32'h0000_0002, 1'b1, 32'h0);
        single(0, 32'h0000_0400, 1'b1, 32'h0);
        single(0, 32'h8000_0000, 1'b1, 32'h0);
        single(0, 32'h0000_03FC, 1'b0, 32'h1135_5678);

        // Flush with two requests in flight and one buffered.
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr[1] = 32'h30 + 32'(4 * i);
            tick();
        end
        req_valid[1] = 1'b0;
        tick();
        chk("flush_pre_valid", 64'(rsp_valid[1]), 64'(1));
        flush[1]     = 1'b1;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h40;
        rsp_ready[1] = 1'b1;
        #1;
        chk("flush_ready_low", 64'(req_ready[1]), 64'(0));
        tick();
        flush[1]     = 1'b0;
        req_valid[1] = 1'b0;
        chk("flush_valid_low", 64'(rsp_valid[1]), 64'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("flush_no_rsp", 64'(rsp_valid[1]), 64'(0));
        end
        single(1, 32'h0000_0010, 1'b0, 32'h7856_3416);

        // Reset between edges while the FIFO holds a response.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h40;
        tick();
        req_addr[0]  = 32'h44;
        tick();
        req_valid[0] = 1'b0;
        chk("mid_pre_valid", 64'(rsp_valid[0]), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid[0]), 64'(0));
        chk("mid_rst_data", 64'(rsp_data[0]), 64'(0));
        chk("mid_rst_ready", 64'(req_ready[0]), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 64'(req_ready[0]), 64'(1));
        chk("mid_rel_valid", 64'(rsp_valid[0]), 64'(0));
        single(0, 32'h0000_0014, 1'b0, 32'h1734_5678);

        single(1, 32'h0000_0000, 1'b0, 32'h7856_3412);
        accept_pop_full(1);
        accept_pop_full(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
